// File: rtl/vga_scan_engine.sv
// Parametrised VGA scan/timing engine: pixel clock-enable divider, h/v counters, frame-buffer read addressing.
// Pins lag the counters by MEM_LAT+1 pixel ticks so that sync, blank and returned pixel data line up.
module vga_scan_engine #(
  parameter int COLOR_W  = 8,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int MEM_LAT  = 1,
  parameter int ADDR_W   = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic               pix_ce,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               h_sync,
  output logic               v_sync,
  output logic               blank_n,
  output logic               sync_n,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare bit so the sync end bound never aliases when the back porch is zero.
  localparam int HW = $clog2(H_TOT + 1);
  localparam int VW = $clog2(V_TOT + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON   = 1'(HS_POL);
  localparam logic          VS_ON   = 1'(VS_POL);

  logic [DW-1:0]           div_cnt;
  logic [HW-1:0]           h_cnt;
  logic [VW-1:0]           v_cnt;
  logic [MEM_LAT-1:0][2:0] pipe;
  logic                    act_q;
  logic                    hs_q;
  logic                    vs_q;
  logic                    h_last;
  logic                    v_last;
  logic                    frame_wrap;
  logic                    raw_act;
  logic                    raw_hs;
  logic                    raw_vs;

  // Gating with rst keeps the strobes quiet while reset is held with en=1.
  assign pix_ce      = rst && en && (div_cnt == DIV_MAX);
  assign h_last      = (h_cnt == H_LAST);
  assign v_last      = (v_cnt == V_LAST);
  assign frame_wrap  = h_last && v_last;
  assign raw_act     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign raw_hs      = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign raw_vs      = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign rd_en       = rst && en && raw_act;
  assign frame_start = pix_ce && frame_wrap;
  assign h_sync      = hs_q ? HS_ON : ~HS_ON;
  assign v_sync      = vs_q ? VS_ON : ~VS_ON;
  assign blank_n     = act_q;
  assign sync_n      = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!en || div_cnt == DIV_MAX) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Linear address of the pixel currently being fetched; parked past the last pixel until the frame wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr <= '0;
    end else if (!en) begin
      rd_addr <= '0;
    end else if (pix_ce) begin
      if (frame_wrap) begin
        rd_addr <= '0;
      end else if (raw_act) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
    end
  end

  // Timing flags ride MEM_LAT ticks to meet the returned data, then one output register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe  <= '0;
      act_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else if (!en) begin
      pipe  <= '0;
      act_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else if (pix_ce) begin
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        pipe[i] <= pipe[i-1];
      end
      pipe[0] <= {raw_act, raw_hs, raw_vs};
      act_q   <= pipe[MEM_LAT-1][2];
      hs_q    <= pipe[MEM_LAT-1][1];
      vs_q    <= pipe[MEM_LAT-1][0];
      r       <= pipe[MEM_LAT-1][2] ? pix_r : '0;
      g       <= pipe[MEM_LAT-1][2] ? pix_g : '0;
      b       <= pipe[MEM_LAT-1][2] ? pix_b : '0;
    end
  end

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine on an 8x6 total raster (4x3 visible), CLK_DIV=2, MEM_LAT=1.
module tb_vga_scan_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_ce, rd_en, h_sync, v_sync, blank_n, sync_n, frame_start;
  logic [18:0] rd_addr;
  logic [7:0]  r, g, b;

  vga_scan_engine #(
    .COLOR_W(8), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CLK_DIV(2), .MEM_LAT(1), .ADDR_W(19)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_ce(pix_ce), .rd_en(rd_en), .rd_addr(rd_addr),
    .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n), .sync_n(sync_n),
    .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Frame buffer with one pixel tick of latency; data is a function of the address.
  logic [7:0] mem_q = 8'd0;
  always @(posedge clk) if (pix_ce && rd_en) mem_q <= rd_addr[7:0];
  assign pix_r = mem_q;
  assign pix_g = ~mem_q;
  assign pix_b = mem_q ^ 8'h5a;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam int N = 200;
  logic s_pce[N], s_bl[N], s_hs[N], s_vs[N], s_fs[N], s_rde[N];
  logic [7:0] s_r[N], s_g[N], s_b[N];
  int addr_seq[15];
  int na, fs_cnt, fs_first, fs_at, first_addr, found;

  initial begin
    // Reset held with en=1
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) step();
    chk("rst_pix_ce", pix_ce, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_h_sync", h_sync, 1);
    chk("rst_v_sync", v_sync, 1);
    chk("rst_blank_n", blank_n, 0);
    chk("rst_r", r, 0);
    chk("rst_g", g, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("sync_n_tied", sync_n, 0);

    // Release between edges; index k = state after the k-th following edge
    rst = 1'b1;
    #1;
    na = 0;
    for (int k = 0; k < N; k++) begin
      s_pce[k] = pix_ce; s_bl[k] = blank_n; s_hs[k] = h_sync; s_vs[k] = v_sync;
      s_fs[k] = frame_start; s_rde[k] = rd_en; s_r[k] = r; s_g[k] = g; s_b[k] = b;
      if (pix_ce && rd_en && na < 15) begin
        addr_seq[na] = int'(rd_addr);
        na++;
      end
      step();
    end

    chk("pce_k0", s_pce[0], 0);
    chk("pce_k1", s_pce[1], 1);
    chk("pce_k2", s_pce[2], 0);
    chk("pce_k3", s_pce[3], 1);
    chk("rd_en_k0", s_rde[0], 1);
    chk("rd_en_k7", s_rde[7], 1);
    chk("rd_en_k8", s_rde[8], 0);

    chk("blank_k3", s_bl[3], 0);
    chk("blank_k4", s_bl[4], 1);
    chk("blank_k11", s_bl[11], 1);
    chk("blank_k12", s_bl[12], 0);
    chk("blank_k19", s_bl[19], 0);
    chk("blank_k20", s_bl[20], 1);

    chk("hs_k13", s_hs[13], 1);
    chk("hs_k14", s_hs[14], 0);
    chk("hs_k17", s_hs[17], 0);
    chk("hs_k18", s_hs[18], 1);
    chk("hs_k30", s_hs[30], 0);
    chk("hs_k34", s_hs[34], 1);

    chk("r_k4", s_r[4], 0);
    chk("r_k6", s_r[6], 1);
    chk("r_k8", s_r[8], 2);
    chk("r_k10", s_r[10], 3);
    chk("r_k12", s_r[12], 0);
    chk("r_k20", s_r[20], 4);
    chk("r_k22", s_r[22], 5);
    chk("g_k6", s_g[6], 254);
    chk("b_k8", s_b[8], 88);
    chk("g_k12", s_g[12], 0);

    chk("vs_k67", s_vs[67], 1);
    chk("vs_k68", s_vs[68], 0);
    chk("vs_k83", s_vs[83], 0);
    chk("vs_k84", s_vs[84], 1);

    fs_cnt = 0;
    fs_first = -1;
    for (int k = 0; k < N; k++) begin
      if (s_fs[k]) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
      end
    end
    chk("fs_count", fs_cnt, 2);
    chk("fs_first", fs_first, 95);
    chk("fs_second", s_fs[191], 1);

    chk("addr_count", na, 15);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("addr_%0d", i), addr_seq[i], (i < 12) ? i : i - 12);
    end

    // Mid-frame disable at v_cnt=1, h_cnt=2
    en = 1'b0;
    step();
    en = 1'b1;
    #1;
    repeat (20) step();
    chk("pre_dis_blank", blank_n, 1);
    chk("pre_dis_addr", rd_addr, 6);
    en = 1'b0;
    step();
    chk("dis_blank", blank_n, 0);
    chk("dis_addr", rd_addr, 0);
    chk("dis_h_sync", h_sync, 1);
    chk("dis_v_sync", v_sync, 1);
    chk("dis_rd_en", rd_en, 0);
    chk("dis_pix_ce", pix_ce, 0);
    chk("dis_r", r, 0);
    repeat (2) step();

    // Re-enable: scan restarts at the origin
    en = 1'b1;
    #1;
    chk("reen_rd_en", rd_en, 1);
    chk("reen_addr", rd_addr, 0);
    fs_at = -1;
    first_addr = -1;
    for (int k = 0; k < 300; k++) begin
      if (pix_ce && rd_en && first_addr < 0) first_addr = int'(rd_addr);
      if (frame_start) begin
        fs_at = k;
        break;
      end
      step();
    end
    chk("reen_first_addr", first_addr, 0);
    chk("reen_fs_at", fs_at, 95);
    step();
    chk("reen_fs_width", frame_start, 0);

    // Asynchronous reset pulse while h_sync is asserted
    found = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (h_sync == 1'b0) begin
        found = 1;
        break;
      end
    end
    chk("hs_low_found", found, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_h_sync", h_sync, 1);
    chk("arst_blank", blank_n, 0);
    chk("arst_pix_ce", pix_ce, 0);
    chk("arst_rd_en", rd_en, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_addr_k0", rd_addr, 0);
    chk("arst_rd_en_k0", rd_en, 1);
    step();
    chk("arst_pce_k1", pix_ce, 1);
    repeat (2) step();
    chk("arst_blank_k3", blank_n, 0);
    step();
    chk("arst_blank_k4", blank_n, 1);
    chk("arst_r_k4", r, 0);
    repeat (2) step();
    chk("arst_r_k6", r, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
